// File: rtl/multdiv_wb_scheduler_if.sv
// Bundle of the issue, mult/div unit, pipeline writeback and register-file
// write port signals seen by the mult/div writeback scheduler.
interface multdiv_wb_scheduler_if;
    // Issue from execute.
    logic        issue_valid;
    logic        issue_is_div;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    // Mult/div unit.
    logic        md_start_mult;
    logic        md_start_div;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    // In-order pipeline writeback.
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        wb_stall;
    // Decode-stage hazard scoreboard.
    logic        busy_valid;
    logic [4:0]  busy_rd;
    // Register-file write port.
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] ctrl_writeData;

    // Environment side: drives requests, observes the port.
    modport master (
        output issue_valid, issue_is_div, issue_rd,
        input  issue_ready,
        input  md_start_mult, md_start_div,
        output md_ready, md_exception, md_result,
        output pipe_we, pipe_rd, pipe_data,
        input  wb_stall, busy_valid, busy_rd,
        input  ctrl_writeEnable, ctrl_writeReg, ctrl_writeData
    );

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_is_div, issue_rd,
        output issue_ready,
        output md_start_mult, md_start_div,
        input  md_ready, md_exception, md_result,
        input  pipe_we, pipe_rd, pipe_data,
        output wb_stall, busy_valid, busy_rd,
        output ctrl_writeEnable, ctrl_writeReg, ctrl_writeData
    );
endinterface

// File: rtl/multdiv_wb_scheduler.sv
// Sequences the multi-cycle mult/div unit and arbitrates the single
// register-file write port between pipeline writeback and mult/div results,
// with a 1-entry deferred-result buffer, WAW kill and starvation override.
module multdiv_wb_scheduler #(
    parameter int unsigned RSTATUS      = 30,
    parameter int unsigned MULT_EXC     = 4,
    parameter int unsigned DIV_EXC      = 5,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    multdiv_wb_scheduler_if.slave   bus
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, PEND} state_e;

    state_e              state_q,     state_d;
    logic [REG_W-1:0]    rd_q,        rd_d;
    logic                is_div_q,    is_div_d;
    logic                kill_q,      kill_d;
    logic                busy_q,      busy_d;
    logic [CNT_W-1:0]    starve_q,    starve_d;
    logic [REG_W-1:0]    buf_reg_q,   buf_reg_d;
    logic [DATA_W-1:0]   buf_data_q,  buf_data_d;
    logic                buf_exc_q,   buf_exc_d;

    logic                pipe_grant;
    logic                res_we;
    logic [REG_W-1:0]    res_reg;
    logic [DATA_W-1:0]   res_data;
    logic                res_exc;
    logic [REG_W-1:0]    md_reg;
    logic [DATA_W-1:0]   md_data;
    logic                port_we;
    logic [REG_W-1:0]    port_reg;
    logic [DATA_W-1:0]   port_data;
    logic                stall;
    logic                start_mult;
    logic                start_div;

    // Exception results overwrite the status register with a fixed code.
    always_comb begin
        md_reg  = bus.md_exception ? REG_W'(RSTATUS) : rd_q;
        md_data = bus.md_result;
        if (bus.md_exception) begin
            md_data = is_div_q ? DATA_W'(DIV_EXC) : DATA_W'(MULT_EXC);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            is_div_q   <= 1'b0;
            kill_q     <= 1'b0;
            busy_q     <= 1'b0;
            starve_q   <= '0;
            buf_reg_q  <= '0;
            buf_data_q <= '0;
            buf_exc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            is_div_q   <= is_div_d;
            kill_q     <= kill_d;
            busy_q     <= busy_d;
            starve_q   <= starve_d;
            buf_reg_q  <= buf_reg_d;
            buf_data_q <= buf_data_d;
            buf_exc_q  <= buf_exc_d;
        end
    end

    // Next-state, port arbitration and unit start pulses.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        is_div_d   = is_div_q;
        kill_d     = kill_q;
        busy_d     = busy_q;
        starve_d   = starve_q;
        buf_reg_d  = buf_reg_q;
        buf_data_d = buf_data_q;
        buf_exc_d  = buf_exc_q;
        pipe_grant = 1'b0;
        res_we     = 1'b0;
        res_reg    = '0;
        res_data   = '0;
        res_exc    = 1'b0;
        stall      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;

        unique case (state_q)
            IDLE: begin
                pipe_grant = bus.pipe_we;
                if (bus.issue_valid) begin
                    rd_d     = bus.issue_rd;
                    is_div_d = bus.issue_is_div;
                    kill_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                pipe_grant = bus.pipe_we;
                start_mult = !is_div_q;
                start_div  = is_div_q;
                state_d    = BUSY;
            end
            BUSY: begin
                pipe_grant = bus.pipe_we;
                if (bus.md_ready) begin
                    if (bus.pipe_we) begin
                        buf_reg_d  = md_reg;
                        buf_data_d = md_data;
                        buf_exc_d  = bus.md_exception;
                        starve_d   = CNT_W'(1);
                        state_d    = PEND;
                    end else begin
                        res_we   = 1'b1;
                        res_reg  = md_reg;
                        res_data = md_data;
                        res_exc  = bus.md_exception;
                        state_d  = IDLE;
                    end
                end
            end
            PEND: begin
                if (starve_q == CNT_W'(STARVE_LIMIT)) begin
                    stall = 1'b1;
                end
                if (stall || !bus.pipe_we) begin
                    res_we   = 1'b1;
                    res_reg  = buf_reg_q;
                    res_data = buf_data_q;
                    res_exc  = buf_exc_q;
                    state_d  = IDLE;
                end else begin
                    pipe_grant = 1'b1;
                    starve_d   = starve_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A younger pipeline write to the same destination makes the result stale.
        if (state_q != IDLE && pipe_grant && bus.pipe_rd == rd_q) begin
            kill_d = 1'b1;
        end

        // Result written or discarded: release the scoreboard entry.
        if (res_we) begin
            busy_d   = 1'b0;
            rd_d     = '0;
            kill_d   = 1'b0;
            starve_d = '0;
        end
    end

    // Write-port mux; stale results and r0 targets leave the port idle.
    always_comb begin
        port_we   = 1'b0;
        port_reg  = '0;
        port_data = '0;
        if (res_we) begin
            if (res_reg != '0 && !(kill_q && !res_exc)) begin
                port_we   = 1'b1;
                port_reg  = res_reg;
                port_data = res_data;
            end
        end else if (pipe_grant && bus.pipe_rd != '0) begin
            port_we   = 1'b1;
            port_reg  = bus.pipe_rd;
            port_data = bus.pipe_data;
        end
    end

    assign bus.issue_ready      = (state_q == IDLE);
    assign bus.md_start_mult    = start_mult;
    assign bus.md_start_div     = start_div;
    assign bus.wb_stall         = stall;
    assign bus.busy_valid       = busy_q;
    assign bus.busy_rd          = rd_q;
    assign bus.ctrl_writeEnable = port_we;
    assign bus.ctrl_writeReg    = port_reg;
    assign bus.ctrl_writeData   = port_data;

endmodule

// File: tb/tb_multdiv_wb_scheduler.sv
// Bench for the mult/div writeback scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_multdiv_wb_scheduler;

    localparam int unsigned LIMIT = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic rst_drv = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rf [32];

    always #5 clock = ~clock;

    multdiv_wb_scheduler_if bus();

    multdiv_wb_scheduler #(
        .RSTATUS(30), .MULT_EXC(4), .DIV_EXC(5), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Architectural register file as seen through the write port.
    always @(posedge clock) begin
        if (bus.ctrl_writeEnable) rf[bus.ctrl_writeReg] <= bus.ctrl_writeData;
    end

    logic [37:0] port;
    logic [9:0]  ctl;
    assign port = {bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.ctrl_writeData};
    assign ctl  = {bus.issue_ready, bus.md_start_mult, bus.md_start_div,
                   bus.wb_stall, bus.busy_valid, bus.busy_rd};

    function automatic logic [37:0] wr(input logic [4:0] r, input logic [31:0] d);
        return {1'b1, r, d};
    endfunction

    function automatic logic [9:0] ctlv(input logic ir, input logic sm, input logic sd,
                                        input logic st, input logic bv, input logic [4:0] brd);
        return {ir, sm, sd, st, bv, brd};
    endfunction

    // Apply one cycle of inputs on the falling edge, settle, then return.
    task automatic drive(input logic iv, input logic idiv, input logic [4:0] ird,
                         input logic mr, input logic mexc, input logic [31:0] mres,
                         input logic pwe, input logic [4:0] prd, input logic [31:0] pdata);
        @(negedge clock);
        reset            = rst_drv;
        bus.issue_valid  = iv;
        bus.issue_is_div = idiv;
        bus.issue_rd     = ird;
        bus.md_ready     = mr;
        bus.md_exception = mexc;
        bus.md_result    = mres;
        bus.pipe_we      = pwe;
        bus.pipe_rd      = prd;
        bus.pipe_data    = pdata;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_drv = 1'b0;
        idle();
        idle();
        checks++;
        if (ctl !== ctlv(1, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, ctlv(1, 0, 0, 0, 0, 0));
        end
        checks++;
        if (port !== 38'd0) begin
            errors++; $display("FAIL reset_port: got %h expected 0", port);
        end
        rst_drv = 1'b1;
        idle();
    endtask

    task automatic test_mult_basic();
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl !== ctlv(1, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL basic_accept: got %b expected %b", ctl, ctlv(1, 0, 0, 0, 0, 0));
        end
        idle();
        checks++;
        if (ctl !== ctlv(0, 1, 0, 0, 1, 5)) begin
            errors++; $display("FAIL basic_launch: got %b expected %b", ctl, ctlv(0, 1, 0, 0, 1, 5));
        end
        idle();
        checks++;
        if (ctl !== ctlv(0, 0, 0, 0, 1, 5)) begin
            errors++; $display("FAIL basic_busy: got %b expected %b", ctl, ctlv(0, 0, 0, 0, 1, 5));
        end
        drive(0, 0, 0, 1, 0, 32'h2A, 0, 0, 0);
        checks++;
        if (port !== wr(5, 32'h2A)) begin
            errors++; $display("FAIL basic_write: got %h expected %h", port, wr(5, 32'h2A));
        end
        idle();
        checks++;
        if (ctl !== ctlv(1, 0, 0, 0, 0, 0) || port !== 38'd0) begin
            errors++; $display("FAIL basic_done: got %b/%h expected %b/0", ctl, port, ctlv(1, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_collision();
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 1, 0, 32'h2A, 1, 7, 32'h11);
        checks++;
        if (port !== wr(7, 32'h11)) begin
            errors++; $display("FAIL collide_pipe: got %h expected %h", port, wr(7, 32'h11));
        end
        idle();
        checks++;
        if (port !== wr(5, 32'h2A) || ctl !== ctlv(0, 0, 0, 0, 1, 5)) begin
            errors++; $display("FAIL collide_drain: got %h/%b expected %h/%b", port, ctl, wr(5, 32'h2A), ctlv(0, 0, 0, 0, 1, 5));
        end
        idle();
        checks++;
        if (ctl !== ctlv(1, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL collide_done: got %b expected %b", ctl, ctlv(1, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_starvation();
        logic [37:0] ep;
        logic [9:0]  ec;
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 1, 0, 32'h55, 1, 7, 32'h11);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 8, 32'h100 + 32'(i));
            if (i == 2) begin
                ep = wr(5, 32'h55);
                ec = ctlv(0, 0, 0, 1, 1, 5);
            end else begin
                ep = wr(8, 32'h100 + 32'(i));
                ec = (i == 3) ? ctlv(1, 0, 0, 0, 0, 0) : ctlv(0, 0, 0, 0, 1, 5);
            end
            checks++;
            if (port !== ep || ctl !== ec) begin
                errors++; $display("FAIL starve_cycle%0d: got %h/%b expected %h/%b", i, port, ctl, ep, ec);
            end
        end
        idle();
    endtask

    task automatic test_exception();
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0);
        idle();
        checks++;
        if (ctl !== ctlv(0, 0, 1, 0, 1, 9)) begin
            errors++; $display("FAIL exc_div_launch: got %b expected %b", ctl, ctlv(0, 0, 1, 0, 1, 9));
        end
        idle();
        drive(0, 0, 0, 1, 1, 32'hDEAD, 0, 0, 0);
        checks++;
        if (port !== wr(30, 32'd5)) begin
            errors++; $display("FAIL exc_div: got %h expected %h", port, wr(30, 32'd5));
        end
        idle();
        drive(1, 0, 9, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        drive(0, 0, 0, 1, 1, 32'hBEEF, 0, 0, 0);
        checks++;
        if (port !== wr(30, 32'd4)) begin
            errors++; $display("FAIL exc_mult: got %h expected %h", port, wr(30, 32'd4));
        end
        idle();
    endtask

    task automatic test_waw_kill();
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 32'h77);
        checks++;
        if (port !== wr(9, 32'h77)) begin
            errors++; $display("FAIL kill_pipe: got %h expected %h", port, wr(9, 32'h77));
        end
        drive(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
        checks++;
        if (port !== 38'd0) begin
            errors++; $display("FAIL kill_discard: got %h expected 0", port);
        end
        idle();
        checks++;
        if (ctl !== ctlv(1, 0, 0, 0, 0, 0) || rf[9] !== 32'h77) begin
            errors++; $display("FAIL kill_done: got %b r9=%h expected %b r9=77", ctl, rf[9], ctlv(1, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        rst_drv = 1'b0;
        idle();
        rst_drv = 1'b1;
        drive(0, 0, 0, 1, 0, 32'h99, 0, 0, 0);
        checks++;
        if (port !== 38'd0 || ctl !== ctlv(1, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL rstmid_stray: got %h/%b expected 0/%b", port, ctl, ctlv(1, 0, 0, 0, 0, 0));
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 1, 0, 32'h5, 0, 0, 0);
        checks++;
        if (port !== 38'd0 || ctl !== ctlv(0, 0, 0, 0, 1, 0)) begin
            errors++; $display("FAIL r0_result: got %h/%b expected 0/%b", port, ctl, ctlv(0, 0, 0, 0, 1, 0));
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'hAB);
        checks++;
        if (port !== 38'd0) begin
            errors++; $display("FAIL r0_pipe: got %h expected 0", port);
        end
        idle();
    endtask

    // Random traffic against a model tracking one outstanding operation.
    task automatic test_random();
        bit out = 0, held = 0, killed = 0, isdiv = 0, hexc = 0;
        int age = 0, starve = 0;
        logic [4:0]  mrd = 0, hreg = 0;
        logic [31:0] hdata = 0;
        for (int n = 0; n < 3000; n++) begin
            bit rs, iv, idiv, mr, mexc, pwe, pgrant, done, stall, wres, texc;
            logic [4:0]  ird, prd, treg;
            logic [31:0] mres, pdata, tdata;
            logic [37:0] ep;
            logic [9:0]  ec;
            rs    = ($urandom_range(0, 199) == 0);
            iv    = ($urandom_range(0, 2) == 0);
            idiv  = $urandom_range(0, 1) == 1;
            ird   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mr    = ($urandom_range(0, 2) == 0);
            mexc  = ($urandom_range(0, 3) == 0);
            mres  = $urandom;
            pwe   = $urandom_range(0, 1) == 1;
            prd   = ($urandom_range(0, 3) == 0) ? mrd : 5'($urandom);
            pdata = $urandom;
            rst_drv = !rs;
            drive(iv, idiv, ird, mr, mexc, mres, pwe, prd, pdata);

            pgrant = pwe; done = 0; stall = 0; wres = 0;
            treg = 0; tdata = 0; texc = 0;
            if (out && held) begin
                if (starve == LIMIT || !pwe) begin
                    stall = (starve == LIMIT);
                    pgrant = 0; done = 1; wres = 1;
                    treg = hreg; tdata = hdata; texc = hexc;
                end
            end else if (out && age >= 2 && mr) begin
                texc  = mexc;
                treg  = mexc ? 5'd30 : mrd;
                tdata = mexc ? (isdiv ? 32'd5 : 32'd4) : mres;
                if (!pwe) begin
                    done = 1; wres = 1;
                end
            end
            ep = 38'd0;
            if (wres && treg != 0 && !(killed && !texc)) ep = wr(treg, tdata);
            if (pgrant && prd != 0) ep = wr(prd, pdata);
            ec = ctlv(!out, out && age == 1 && !isdiv, out && age == 1 && isdiv,
                      stall, out, out ? mrd : 5'd0);

            if (!rs) begin
                checks++;
                if (port !== ep) begin
                    errors++; $display("FAIL rand_port@%0d: got %h expected %h", n, port, ep);
                end
                checks++;
                if (ctl !== ec) begin
                    errors++; $display("FAIL rand_ctl@%0d: got %b expected %b", n, ctl, ec);
                end
            end

            if (rs) begin
                out = 0; held = 0; killed = 0; mrd = 0;
            end else begin
                if (out && pgrant && prd == mrd) killed = 1;
                if (out && held && !done) starve++;
                if (out && !held && age >= 2 && mr && pwe) begin
                    held = 1; starve = 1; hreg = treg; hdata = tdata; hexc = texc;
                end
                if (done) begin
                    out = 0; held = 0; killed = 0; mrd = 0;
                end else if (out) begin
                    age++;
                end else if (iv) begin
                    out = 1; age = 1; mrd = ird; isdiv = idiv; killed = 0;
                end
            end
        end
        rst_drv = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_collision();
        test_starvation();
        test_exception();
        test_waw_kill();
        test_reset_mid();
        rst_drv = 1'b0;
        idle();
        rst_drv = 1'b1;
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
